// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator
//   Sums COUNT consecutive results from an upstream 16-bit adder. Each result
//   is treated as the 17-bit unsigned value {Carry, Z}. The completed sum is
//   presented on out_sum with a valid/ready handshake. The sum wraps modulo
//   2^ACC_W.
//
//   Optional feature: define ACC_OVF_FLAG_EN to add the ovf output. ovf is set
//   when any add in the current sum carries out of bit ACC_W-1.
//
// Parameters
//   COUNT : results summed per output (1..255)
//   ACC_W : accumulator / out_sum width (17..32)
//
// Ports
//   clk       : clock; all state updates on the rising edge
//   rst       : synchronous, active-high reset; highest priority
//   clear     : synchronous abort; discards the partial sum or the held result
//   Z, Carry  : upstream adder result
//   in_valid  : Z/Carry are valid
//   in_ready  : block accepts a beat (ACCUM state)
//   out_sum   : completed sum; holds its last value while out_valid=0
//   out_valid : out_sum is valid (HOLD state)
//   out_ready : downstream consumes out_sum
//   ovf       : (ACC_OVF_FLAG_EN only) overflow flag for the presented sum
module adder_sum_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [15:0]      Z,
  input  logic             Carry,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_valid,
  input  logic             out_ready
`ifdef ACC_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc;
  logic [7:0]         cnt;
  logic [ACC_W-1:0]   opnd;
  logic [ACC_W-1:0]   add_s;
  logic               accept;
  logic               last;

  assign opnd   = ACC_W'({Carry, Z});
  assign accept = in_valid && (state == ACCUM);
  assign last   = (cnt == 8'(COUNT - 1));

`ifdef ACC_OVF_FLAG_EN
  logic add_c;
  logic ovf_run;  // carry seen by an earlier beat of the sum in progress
  assign {add_c, add_s} = {1'b0, acc} + {1'b0, opnd};
`else
  assign add_s = acc + opnd;
`endif

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  // next-state logic
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ACCUM;
    end else begin
      case (state)
        ACCUM: if (accept && last) state_next = HOLD;
        HOLD:  if (out_ready)      state_next = ACCUM;
        default: state_next = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      out_sum <= '0;
`ifdef ACC_OVF_FLAG_EN
      ovf     <= 1'b0;
      ovf_run <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (clear) begin
        // out_sum keeps its last value; only the partial sum is dropped
        acc     <= '0;
        cnt     <= '0;
`ifdef ACC_OVF_FLAG_EN
        ovf     <= 1'b0;
        ovf_run <= 1'b0;
`endif
      end else if (accept) begin
        if (last) begin
          out_sum <= add_s;
          // acc/cnt are zeroed now; nothing touches them while in HOLD
          acc     <= '0;
          cnt     <= '0;
`ifdef ACC_OVF_FLAG_EN
          ovf     <= ovf_run | add_c;
          ovf_run <= 1'b0;
`endif
        end else begin
          acc <= add_s;
          cnt <= cnt + 8'd1;
`ifdef ACC_OVF_FLAG_EN
          ovf_run <= ovf_run | add_c;
`endif
        end
      end else if ((state == HOLD) && out_ready) begin
        acc <= '0;
        cnt <= '0;
`ifdef ACC_OVF_FLAG_EN
        ovf <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
module tb_adder_sum_accumulator;

  localparam int ACC_W = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] Z = '0;
  logic        Carry = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic             ir4, ov4, ir10, ov10, ir1, ov1;
  logic [ACC_W-1:0] os4, os10, os1;
`ifdef ACC_OVF_FLAG_EN
  logic             of4, of10, of1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // three instances share stimulus; each test checks the one it targets
  adder_sum_accumulator #(.COUNT(4), .ACC_W(ACC_W)) u4 (
    .clk(clk), .rst(rst), .clear(clear), .Z(Z), .Carry(Carry),
    .in_valid(in_valid), .in_ready(ir4), .out_sum(os4), .out_valid(ov4),
    .out_ready(out_ready)
`ifdef ACC_OVF_FLAG_EN
    , .ovf(of4)
`endif
  );

  adder_sum_accumulator #(.COUNT(10), .ACC_W(ACC_W)) u10 (
    .clk(clk), .rst(rst), .clear(clear), .Z(Z), .Carry(Carry),
    .in_valid(in_valid), .in_ready(ir10), .out_sum(os10), .out_valid(ov10),
    .out_ready(out_ready)
`ifdef ACC_OVF_FLAG_EN
    , .ovf(of10)
`endif
  );

  adder_sum_accumulator #(.COUNT(1), .ACC_W(ACC_W)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .Z(Z), .Carry(Carry),
    .in_valid(in_valid), .in_ready(ir1), .out_sum(os1), .out_valid(ov1),
    .out_ready(out_ready)
`ifdef ACC_OVF_FLAG_EN
    , .ovf(of1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [16:0] v);
    in_valid = 1'b1;
    {Carry, Z} = v;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // reference model state for the random sweep
  longint      q[$];
  longint      m_exp;
  bit          m_hold;
  int          n_acc;
  logic [16:0] v;
  longint      s;

  initial begin
    // reset state
    do_reset();
    chk("rst_out_valid", 32'(ov4), 0);
    chk("rst_out_sum",   32'(os4), 0);
    chk("rst_in_ready",  32'(ir4), 1);
`ifdef ACC_OVF_FLAG_EN
    chk("rst_ovf", 32'(of4), 0);
`endif

    // 1,2,3,4 -> 10, then restart from 0
    out_ready = 1'b1;
    beat(17'd1); beat(17'd2); beat(17'd3); beat(17'd4);
    in_valid = 1'b0;
    chk("basic_valid", 32'(ov4), 1);
    chk("basic_sum",   32'(os4), 10);
    step();
    chk("basic_release_valid", 32'(ov4), 0);
    chk("basic_release_ready", 32'(ir4), 1);
    beat(17'd5); beat(17'd6); beat(17'd7); beat(17'd8);
    in_valid = 1'b0;
    chk("restart_sum",   32'(os4), 26);
    chk("restart_valid", 32'(ov4), 1);

    // ten max operands into COUNT=10 wrap modulo 2^20
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) beat(17'h1FFFF);
    in_valid = 1'b0;
    chk("wrap_valid", 32'(ov10), 1);
    chk("wrap_sum",   32'(os10), 262134);
`ifdef ACC_OVF_FLAG_EN
    chk("wrap_ovf", 32'(of10), 1);
    out_ready = 1'b1;
    step();
    chk("wrap_ovf_cleared", 32'(of10), 0);
`endif

    // HOLD stalls while out_ready=0; inputs ignored
    do_reset();
    out_ready = 1'b0;
    beat(17'd1); beat(17'd2); beat(17'd3); beat(17'd4);
    for (int i = 0; i < 5; i++) begin
      beat(17'd100);
      chk("hold_in_ready",  32'(ir4), 0);
      chk("hold_out_valid", 32'(ov4), 1);
      chk("hold_out_sum",   32'(os4), 10);
    end
    // release cycle: the offered beat must not be taken
    out_ready = 1'b1;
    beat(17'd100);
    chk("hold_release_valid", 32'(ov4), 0);
    beat(17'd1); beat(17'd1); beat(17'd1); beat(17'd1);
    in_valid = 1'b0;
    chk("hold_after_sum", 32'(os4), 4);

    // clear drops a partial sum
    do_reset();
    out_ready = 1'b0;
    beat(17'd3); beat(17'd5);
    in_valid = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_in_ready", 32'(ir4), 1);
    beat(17'd1); beat(17'd1); beat(17'd1); beat(17'd1);
    in_valid = 1'b0;
    chk("clear_sum",   32'(os4), 4);
    chk("clear_valid", 32'(ov4), 1);

    // clear in HOLD beats out_ready; clear beats a completing beat
    out_ready = 1'b1; clear = 1'b1;
    step();
    chk("clear_hold_valid", 32'(ov4), 0);
    clear = 1'b0;
    beat(17'd1); beat(17'd1); beat(17'd1);
    clear = 1'b1;
    beat(17'd1);
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clear_vs_beat_valid", 32'(ov4), 0);
    beat(17'd2); beat(17'd2); beat(17'd2); beat(17'd2);
    in_valid = 1'b0;
    chk("clear_vs_beat_sum", 32'(os4), 8);

    // COUNT=1: rst in HOLD together with out_ready
    do_reset();
    out_ready = 1'b0;
    beat(17'd7);
    in_valid = 1'b0;
    chk("c1_valid", 32'(ov1), 1);
    chk("c1_sum",   32'(os1), 7);
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0;
    chk("c1_rst_valid", 32'(ov1), 0);
    chk("c1_rst_sum",   32'(os1), 0);
    chk("c1_rst_ready", 32'(ir1), 1);

    // random sweep of COUNT=4 instance against a queue-based model
    do_reset();
    q.delete();
    m_hold = 1'b0; m_exp = 0; n_acc = 0;
    for (int cyc = 0; cyc < 6000 && n_acc < 1000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 99) == 0);
      v         = 17'($urandom_range(0, 131071));
      {Carry, Z} = v;
      #1;
      chk("sweep_in_ready", 32'(ir4), 32'(!m_hold));
      if (clear) begin
        q.delete();
        m_hold = 1'b0;
        if (in_valid && !m_hold) n_acc++;
      end else if (!m_hold && in_valid) begin
        q.push_back(longint'(v));
        n_acc++;
        if (q.size() == 4) begin
          s = 0;
          foreach (q[k]) s += q[k];
          m_exp  = s % (longint'(1) << ACC_W);
          m_hold = 1'b1;
          q.delete();
        end
      end else if (m_hold && out_ready) begin
        m_hold = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("sweep_out_valid", 32'(ov4), 32'(m_hold));
      if (m_hold) chk("sweep_out_sum", 32'(os4), 32'(m_exp));
    end
    in_valid = 1'b0; clear = 1'b0;
    chk("sweep_beats", 32'(n_acc), 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_sum_accumulator.md
ADDER_SUM_ACCUMULATOR -- requirements
Module: adder_sum_accumulator

Interface
REQ-001 SHALL provide parameter: COUNT, 4, number of adder results summed per output (legal 1..255).
REQ-002 SHALL provide parameter: ACC_W, 20, accumulator and out_sum width in bits (legal 17..32).
REQ-003 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port: clear  input  1  synchronous abort; discards the partial sum.
REQ-006 SHALL provide port: Z  input  16  sum output of the upstream 16-bit adder.
REQ-007 SHALL provide port: Carry  input  1  carry output of the upstream 16-bit adder.
REQ-008 SHALL provide port: in_valid  input  1  Z/Carry hold a valid result.
REQ-009 SHALL provide port: in_ready  output  1  block accepts a result this cycle.
REQ-010 SHALL provide port: out_sum  output  ACC_W  completed accumulated sum.
REQ-011 SHALL provide port: out_valid  output  1  out_sum is valid.
REQ-012 SHALL provide port: out_ready  input  1  downstream consumes out_sum.
REQ-013 SHALL provide port, only when ACC_OVF_FLAG_EN is defined: ovf  output  1  overflow flag for the current sum.

Function
REQ-014 SHALL treat each input beat as the 17-bit unsigned operand {Carry, Z}, zero-extended to ACC_W.
REQ-015 SHALL accept a beat only when in_valid and in_ready are both 1 at a rising edge.
REQ-016 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-017 ACCUM: each accepted beat SHALL add its operand to acc, modulo 2^ACC_W (wrap-around), and increment the 8-bit beat counter.
REQ-018 ACCUM: when the COUNT-th beat is accepted, the block SHALL register acc + operand into out_sum, move to HOLD, and assert out_valid on the next cycle (1-cycle latency).
REQ-019 HOLD: out_sum (and ovf if present) SHALL remain stable, and inputs SHALL be ignored, until out_ready=1.
REQ-020 HOLD with out_ready=1: the block SHALL return to ACCUM with acc=0 and counter=0 on the next cycle; a beat offered in that same cycle is not accepted, because in_ready=0.
REQ-021 With COUNT=1, every accepted beat SHALL produce one output; throughput is one result every 2 cycles at best.
REQ-022 clear=1 in any state SHALL set acc=0, counter=0, out_valid=0 and state=ACCUM on the next cycle.
REQ-023 clear SHALL take priority over a simultaneous accepted beat and over a simultaneous out_ready handshake; the output is dropped.
REQ-024 out_sum SHALL retain its last value when out_valid=0; its value is only meaningful while out_valid=1.

Reset
REQ-025 On rst=1 at a rising edge: state=ACCUM, acc=0, counter=0, out_sum=0, out_valid=0, ovf=0; in_ready SHALL be 1 from the next cycle.
REQ-026 rst SHALL take priority over clear and over all handshakes, including mid-accumulation and in HOLD.

Configuration
REQ-027 Macro ACC_OVF_FLAG_EN defined: the ovf port SHALL exist and SHALL be set when any add in the current sum carries out of bit ACC_W-1.
REQ-028 With ACC_OVF_FLAG_EN defined: ovf SHALL be presented alongside out_valid, and SHALL be cleared by the HOLD->ACCUM transition, by clear, and by rst.
REQ-029 Macro ACC_OVF_FLAG_EN undefined: the ovf port and its logic SHALL be absent; the sum still wraps modulo 2^ACC_W.

Verification
REQ-030 COUNT=4, ACC_W=20, beats {Carry,Z}=1,2,3,4 on consecutive cycles, out_ready=1 -> out_valid=1 one cycle after the 4th beat, out_sum=10, then next accepted sum restarts from 0.
REQ-031 COUNT=10, ACC_W=20, ten beats of Carry=1, Z=16'hFFFF -> out_sum=262134 (1310710 mod 2^20); with ACC_OVF_FLAG_EN, ovf=1.
REQ-032 COUNT=4, result in HOLD, out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_sum/out_valid stable, no beat accepted, counter unchanged.
REQ-033 COUNT=4, after 2 beats (3, 5) assert clear for 1 cycle, then beats 1,1,1,1 -> out_sum=4.
REQ-034 COUNT=1, assert rst in HOLD with out_ready=1 on the same edge -> next cycle out_valid=0, out_sum=0, in_ready=1.
REQ-035 Exhaustive-style sweep: random beat stream of 1000 beats with random in_valid/out_ready gaps -> each out_sum equals the reference model sum mod 2^ACC_W.
